// File: rtl/cipher_pkg.sv
// Shared types and helpers for the ciphertext framer: frame FSM states,
// default start-of-frame marker and the checksum accumulation step.
package cipher_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_SOF = 3'd1,
    HDR_LEN = 3'd2,
    PAYLOAD = 3'd3,
    CSUM    = 3'd4
  } frame_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  function automatic logic [7:0] xor_accum(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with synchronous reset; the head byte is presented
// combinationally so a pop and its data use the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign level   = level_r;
  assign full    = (level_r == LW'(DEPTH));
  assign empty   = (level_r == LW'(0));

endmodule

// File: rtl/cipher_framer_chk.sv
// Property checks for the framer: the FIFO is never popped while empty,
// and a stalled output byte is held until the link accepts it.
module cipher_framer_chk (
  input logic       clk,
  input logic       rst,
  input logic       pop,
  input logic       empty,
  input logic       dout_v,
  input logic       dout_rdy,
  input logic [7:0] dout
);

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    (dout_v && !dout_rdy) |=> (dout_v && $stable(dout)));

endmodule

// File: rtl/cipher_framer.sv
// Buffers the ciphertext byte stream and emits SOF, LEN, payload and XOR
// checksum frames on a registered valid/ready byte interface.
module cipher_framer
  import cipher_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         PAYLOAD_LEN = 8,
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             din,
  input  logic                   v,
  input  logic                   flush,
  input  logic                   ovf_clr,
  output logic [7:0]             dout,
  output logic                   dout_v,
  input  logic                   dout_rdy,
  output logic                   busy,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;

  frame_state_t  state_r, state_nxt_s;
  logic [7:0]    dout_r, dout_nxt_s;
  logic [7:0]    csum_r, csum_nxt_s;
  logic [7:0]    len_r, len_nxt_s;
  logic [7:0]    remcnt_r, remcnt_nxt_s;
  logic [7:0]    len_cap_s, head_s;
  logic          dout_v_r, dout_v_nxt_s;
  logic          busy_r, ovf_r;
  logic          push_s, pop_s, full_s, empty_s;
  logic          xfer_s, start_s, full_frame_s;
  logic [LW-1:0] level_s;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data (din),
    .pop     (pop_s),
    .rd_data (head_s),
    .level   (level_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  cipher_framer_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .pop      (pop_s),
    .empty    (empty_s),
    .dout_v   (dout_v_r),
    .dout_rdy (dout_rdy),
    .dout     (dout_r)
  );

  // Full is judged on the registered level, so a same-cycle pop cannot rescue a byte.
  assign push_s       = v && !full_s;
  assign xfer_s       = dout_v_r && dout_rdy;
  assign full_frame_s = (level_s >= LW'(PAYLOAD_LEN));
  assign start_s      = full_frame_s || (flush && !empty_s);
  assign len_cap_s    = full_frame_s ? 8'(PAYLOAD_LEN) : 8'(level_s);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state decode; every header/payload step advances only on a transfer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start_s) state_nxt_s = HDR_SOF; else state_nxt_s = IDLE;
      HDR_SOF: if (xfer_s)  state_nxt_s = HDR_LEN; else state_nxt_s = HDR_SOF;
      HDR_LEN: if (xfer_s)  state_nxt_s = PAYLOAD; else state_nxt_s = HDR_LEN;
      PAYLOAD: if (xfer_s && remcnt_r == 8'd1) state_nxt_s = CSUM; else state_nxt_s = PAYLOAD;
      CSUM:    if (xfer_s)  state_nxt_s = IDLE;    else state_nxt_s = CSUM;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the output/datapath registers and the FIFO pop strobe.
  always_comb begin
    dout_nxt_s   = dout_r;
    dout_v_nxt_s = dout_v_r;
    csum_nxt_s   = csum_r;
    len_nxt_s    = len_r;
    remcnt_nxt_s = remcnt_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          len_nxt_s    = len_cap_s;
          dout_nxt_s   = SOF_BYTE;
          dout_v_nxt_s = 1'b1;
          csum_nxt_s   = 8'h00;
        end else begin
          dout_v_nxt_s = 1'b0;
        end
      end
      HDR_SOF: begin
        if (xfer_s) begin
          dout_nxt_s   = len_r;
          remcnt_nxt_s = len_r;
        end else begin
          dout_nxt_s   = dout_r;
        end
      end
      HDR_LEN: begin
        if (xfer_s) begin
          pop_s      = 1'b1;
          dout_nxt_s = head_s;
          csum_nxt_s = xor_accum(csum_r, head_s);
        end else begin
          dout_nxt_s = dout_r;
        end
      end
      PAYLOAD: begin
        if (xfer_s) begin
          remcnt_nxt_s = remcnt_r - 8'd1;
          if (remcnt_r > 8'd1) begin
            pop_s      = 1'b1;
            dout_nxt_s = head_s;
            csum_nxt_s = xor_accum(csum_r, head_s);
          end else begin
            dout_nxt_s = csum_r;
          end
        end else begin
          dout_nxt_s = dout_r;
        end
      end
      CSUM: begin
        if (xfer_s) dout_v_nxt_s = 1'b0;
        else        dout_v_nxt_s = 1'b1;
      end
      default: dout_v_nxt_s = 1'b0;
    endcase
  end

  // Output and datapath registers; overflow set takes priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r   <= 8'h00;
      dout_v_r <= 1'b0;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
      csum_r   <= 8'h00;
      len_r    <= 8'h00;
      remcnt_r <= 8'h00;
    end else begin
      dout_r   <= dout_nxt_s;
      dout_v_r <= dout_v_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
      csum_r   <= csum_nxt_s;
      len_r    <= len_nxt_s;
      remcnt_r <= remcnt_nxt_s;
      if (v && full_s)   ovf_r <= 1'b1;
      else if (ovf_clr)  ovf_r <= 1'b0;
      else               ovf_r <= ovf_r;
    end
  end

  assign dout   = dout_r;
  assign dout_v = dout_v_r;
  assign busy   = busy_r;
  assign ovf    = ovf_r;
  assign level  = level_s;

endmodule

// File: doc/cipher_framer.md
Name: cipher_framer

Overview:
- Sits directly downstream of the encryption stage.
- Consumes its registered ciphertext byte stream (8-bit data plus a one-cycle valid, no backpressure) and buffers it in an internal FIFO.
- Emits framed packets on a valid/ready byte interface to the link/transmit logic.
- Frame format: SOF byte, LEN byte, LEN payload bytes, then an XOR checksum of the payload.

Parameters:
- DEPTH, 16: FIFO depth in bytes; power of two, at least 4.
- PAYLOAD_LEN, 8: payload bytes per full frame; range 1..DEPTH, at most 255.
- SOF_BYTE, 8'hA5: start-of-frame marker.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  8  ciphertext byte from the encryption stage.
- v  in  1  din valid, one byte per cycle when high.
- flush  in  1  level; allows a short frame when fewer than PAYLOAD_LEN bytes are buffered.
- ovf_clr  in  1  clears the ovf flag.
- dout  out  8  framed output byte.
- dout_v  out  1  dout valid.
- dout_rdy  in  1  downstream ready.
- busy  out  1  high while a frame is in progress (state != IDLE).
- ovf  out  1  sticky overflow flag.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge):
  - FIFO pointers and level go to 0.
  - state goes to IDLE.
  - dout=8'h00, dout_v=0, busy=0, ovf=0, checksum accumulator=0.
  - Reset mid-frame abandons the frame immediately and discards buffered bytes. No trailing bytes are emitted.
- FIFO write:
  - When v=1 and level<DEPTH, din is written at the edge.
  - When v=1 and level==DEPTH, the byte is dropped and ovf is set. A pop in the same cycle does not rescue it; full is judged on the registered level.
  - ovf stays set until ovf_clr=1 or rst. If a set and ovf_clr coincide, the set wins.
- Simultaneous push and pop: level is unchanged, both pointers advance.
- All outputs are registered. dout/dout_v must be stable while dout_v=1 and dout_rdy=0.
- A transfer occurs when dout_v=1 and dout_rdy=1 at a clk edge.
- FSM states: IDLE, HDR_SOF, HDR_LEN, PAYLOAD, CSUM.
  - IDLE:
    - If level>=PAYLOAD_LEN, capture len=PAYLOAD_LEN.
    - Otherwise, if flush=1 and level>0, capture len=level.
    - On either, go to HDR_SOF. The next cycle shows dout=SOF_BYTE, dout_v=1. The checksum is cleared.
    - level==0 with flush=1: stay in IDLE, no output.
  - HDR_SOF: on transfer, go to HDR_LEN with dout=len and remcnt=len.
  - HDR_LEN: on transfer, go to PAYLOAD. The FIFO head is popped and presented on dout. csum ^= byte.
  - PAYLOAD: on each transfer, decrement remcnt.
    - If remcnt>1, pop the next byte, present it and XOR it into csum.
    - If remcnt==1, go to CSUM with dout=csum.
  - CSUM: on transfer, go to IDLE with dout_v=0.
- Back-to-back frames: the earliest next SOF appears one cycle after the CSUM transfer, when the IDLE condition holds. That gives one IDLE bubble between frames.
- Pops only occur in PAYLOAD setup, and len never exceeds level at capture. Underflow is therefore impossible; an assertion checks pop with level==0 never happens.
- Latency: a byte written at edge N is counted in level after edge N. The earliest SOF is valid after edge N+1.
- Widths: remcnt and len are 8 bits. The checksum is an 8-bit XOR over payload bytes only.

Decomposition:
- Package cipher_pkg:
  - frame_state_t enum (IDLE, HDR_SOF, HDR_LEN, PAYLOAD, CSUM).
  - default SOF constant 8'hA5.
  - function xor_accum(csum, byte).
- Sub-module byte_fifo (DEPTH parameter):
  - synchronous-reset circular buffer with push, pop, rd_data (combinational head), level and full/empty.
  - the framer FSM and output registers live in cipher_framer.

Test Plan:
- Full frame: dout_rdy=1; push 8 bytes 01..08 back-to-back.
  - Expect A5,08,01..08,08 on consecutive cycles (checksum 01^..^08 = 08). busy falls after the CSUM transfer.
- Flush short frame: push 3C,C3,FF; assert flush.
  - Expect A5,03,3C,C3,FF,00 (checksum 00). level returns to 0.
- Backpressure: toggle dout_rdy pseudo-randomly during a full frame.
  - dout holds while dout_rdy=0; the output sequence is identical to the first scenario.
- Overflow: dout_rdy=0; push 17 bytes with DEPTH=16.
  - level=16, ovf=1, and the 17th byte is absent from output.
  - ovf_clr pulse clears ovf. A set coinciding with ovf_clr keeps ovf=1.
- Continuous stream: push 16 bytes 00..0F with dout_rdy=1.
  - Expect two frames: A5,08,00..07,00 then A5,08,08..0F,00, with one idle cycle between.
- Reset mid-frame: assert rst during PAYLOAD of a frame with 4 bytes still buffered.
  - Next cycle: dout_v=0, busy=0, level=0, dout=00. A fresh push of 8 bytes yields a correct new frame.
